// File: rtl/alu.sv
// RV32IM execute-stage ALU: decodes opcode/funct3/funct7 into add/sub, logic, shift, compare, multiply (optional divide with ALU_DIV_EN).
// Latency: 1 cycle, inputs registered into result/zero/status; one new operation accepted every clock.
// Backpressure: none; no handshake, the ALU always accepts and always presents a result.
module alu #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] op1,
   input  logic [WIDTH-1:0] op2,
   input  logic [6:0]       opcode,
   input  logic [2:0]       funct3,
   input  logic [6:0]       funct7,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             status
);

   localparam int SHW = $clog2(WIDTH);

   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_I      = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;
   localparam logic [6:0] F7_MEXT = 7'b0000001;

   logic [SHW-1:0]     shamt;
   logic [WIDTH-1:0]   add_r, sub_r, sll_r, srl_r, sra_r, slt_r, sltu_r;
   logic               mul_a_sgn, mul_b_sgn;
   logic [2*WIDTH-1:0] mul_a, mul_b, prod;
   logic [WIDTH-1:0]   res_c;
   logic               ill_c;

   assign shamt  = op2[SHW-1:0];
   assign add_r  = op1 + op2;
   assign sub_r  = op1 - op2;
   assign sll_r  = op1 << shamt;
   assign srl_r  = op1 >> shamt;
   assign sra_r  = $signed(op1) >>> shamt;
   assign slt_r  = {{(WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
   assign sltu_r = {{(WIDTH-1){1'b0}}, (op1 < op2)};

   // One shared multiplier: operands are sign- or zero-extended to 2*WIDTH so the
   // truncated 2*WIDTH product is exact for MUL, MULH, MULHSU and MULHU alike.
   assign mul_a_sgn = (funct3 == 3'b001) || (funct3 == 3'b010);
   assign mul_b_sgn = (funct3 == 3'b001);
   assign mul_a     = {{WIDTH{mul_a_sgn & op1[WIDTH-1]}}, op1};
   assign mul_b     = {{WIDTH{mul_b_sgn & op2[WIDTH-1]}}, op2};
   assign prod      = mul_a * mul_b;

`ifdef ALU_DIV_EN
   logic [WIDTH-1:0] div_r, divu_r, rem_r, remu_r;
   logic             div_zero, div_ovf;

   assign div_zero = (op2 == '0);
   assign div_ovf  = (op1 == {1'b1, {(WIDTH-1){1'b0}}}) && (op2 == '1);

   // Divide/remainder with the RISC-V results for divide-by-zero and signed overflow.
   always_comb begin
      div_r  = '1;
      divu_r = '1;
      rem_r  = op1;
      remu_r = op1;
      if (!div_zero) begin
         divu_r = op1 / op2;
         remu_r = op1 % op2;
         if (div_ovf) begin
            div_r = op1;
            rem_r = '0;
         end else begin
            div_r = $signed(op1) / $signed(op2);
            rem_r = $signed(op1) % $signed(op2);
         end
      end
   end
`endif

   // Decode the instruction fields and select the same-cycle result or flag illegal.
   always_comb begin
      res_c = '0;
      ill_c = 1'b0;
      case (opcode)
         OPC_R: begin
            case (funct7)
               F7_BASE: begin
                  case (funct3)
                     3'b000:  res_c = add_r;
                     3'b001:  res_c = sll_r;
                     3'b010:  res_c = slt_r;
                     3'b011:  res_c = sltu_r;
                     3'b100:  res_c = op1 ^ op2;
                     3'b101:  res_c = srl_r;
                     3'b110:  res_c = op1 | op2;
                     default: res_c = op1 & op2;
                  endcase
               end
               F7_ALT: begin
                  case (funct3)
                     3'b000:  res_c = sub_r;
                     3'b101:  res_c = sra_r;
                     default: ill_c = 1'b1;
                  endcase
               end
               F7_MEXT: begin
                  case (funct3)
                     3'b000:  res_c = prod[WIDTH-1:0];
                     3'b001,
                     3'b010,
                     3'b011:  res_c = prod[2*WIDTH-1:WIDTH];
`ifdef ALU_DIV_EN
                     3'b100:  res_c = div_r;
                     3'b101:  res_c = divu_r;
                     3'b110:  res_c = rem_r;
                     default: res_c = remu_r;
`else
                     default: ill_c = 1'b1;
`endif
                  endcase
               end
               default: ill_c = 1'b1;
            endcase
         end
         OPC_I: begin
            case (funct3)
               3'b000:  res_c = add_r;
               3'b001: begin
                  if (funct7 == F7_BASE) res_c = sll_r;
                  else                   ill_c = 1'b1;
               end
               3'b010:  res_c = slt_r;
               3'b011:  res_c = sltu_r;
               3'b100:  res_c = op1 ^ op2;
               3'b101: begin
                  if (funct7 == F7_BASE)     res_c = srl_r;
                  else if (funct7 == F7_ALT) res_c = sra_r;
                  else                       ill_c = 1'b1;
               end
               3'b110:  res_c = op1 | op2;
               default: res_c = op1 & op2;
            endcase
         end
         OPC_LOAD, OPC_STORE, OPC_AUIPC, OPC_JAL, OPC_JALR: res_c = add_r;
         OPC_BRANCH: res_c = sub_r;
         OPC_LUI:    res_c = op2;
         default:    ill_c = 1'b1;
      endcase
      if (ill_c) res_c = '0;
   end

   // Register result and flags; zero is taken from the same computed value as result.
   always_ff @(posedge clk) begin
      if (rst) begin
         result <= '0;
         zero   <= 1'b1;
         status <= 1'b0;
      end else begin
         result <= res_c;
         zero   <= (res_c == '0);
         status <= ill_c;
      end
   end

endmodule

// File: tb/tb_alu.sv
// Testbench for alu: directed cases from the plan plus randomized ops against a reference model.
// Latency: each op is driven on the falling edge and checked 1 ns after the next rising edge.
// Backpressure: none; one op per clock.
module tb_alu;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] op1, op2;
   logic [6:0]   opcode, funct7;
   logic [2:0]   funct3;
   logic [W-1:0] result;
   logic         zero, status;

   int n_cmp = 0;
   int n_err = 0;

   alu #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .op1(op1), .op2(op2),
      .opcode(opcode), .funct3(funct3), .funct7(funct7),
      .result(result), .zero(zero), .status(status)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference model: straight from the instruction semantics using integer arithmetic.
   function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic [6:0] opc,
                                 input logic [2:0] f3, input logic [6:0] f7,
                                 output logic [31:0] r, output logic ill);
      int          sa, sb, sh;
      longint      p;
      logic [63:0] pu;
      logic        is_r, is_i;
      sa  = $signed(a);
      sb  = $signed(b);
      sh  = int'(b % 32);
      r   = 32'h0;
      ill = 1'b0;
      is_r = (opc == 7'h33);
      is_i = (opc == 7'h13);
      if (is_r && f7 == 7'h01) begin
         case (f3)
            3'd0: r = a * b;
            3'd1: begin p = longint'(sa) * longint'(sb); r = p[63:32]; end
            3'd2: begin p = longint'(sa) * longint'({32'h0, b}); r = p[63:32]; end
            3'd3: begin pu = {32'h0, a} * {32'h0, b}; r = pu[63:32]; end
`ifdef ALU_DIV_EN
            3'd4: r = (b == 0) ? 32'hFFFF_FFFF : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : 32'(sa / sb);
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: r = (b == 0) ? a : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h0 : 32'(sa % sb);
            3'd7: r = (b == 0) ? a : a % b;
`else
            default: ill = 1'b1;
`endif
         endcase
      end else if (is_r || is_i) begin
         // Legality first, then the shared funct3 meaning.
         if (is_r && !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)))) ill = 1'b1;
         if (is_i && f3 == 3'd1 && f7 != 7'h00) ill = 1'b1;
         if (is_i && f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) ill = 1'b1;
         case (f3)
            3'd0: r = (is_r && f7 == 7'h20) ? a - b : a + b;
            3'd1: r = a * (32'd1 << sh);
            3'd2: r = (sa < sb) ? 32'd1 : 32'd0;
            3'd3: r = (a < b) ? 32'd1 : 32'd0;
            3'd4: r = a ^ b;
            3'd5: r = (f7 == 7'h20) ? 32'(sa >>> sh) : a / (32'd1 << sh);
            3'd6: r = a | b;
            3'd7: r = a & b;
         endcase
      end else begin
         case (opc)
            7'h03, 7'h23, 7'h17, 7'h6F, 7'h67: r = a + b;
            7'h63: r = a - b;
            7'h37: r = b;
            default: ill = 1'b1;
         endcase
      end
      if (ill) r = 32'h0;
   endfunction

   task automatic apply(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] exp_r, input logic exp_st);
      @(negedge clk);
      op1 = a; op2 = b; opcode = opc; funct3 = f3; funct7 = f7;
      @(posedge clk);
      #1;
      check({tag, ".result"}, 64'(result), 64'(exp_r));
      check({tag, ".zero"},   64'(zero),   64'(exp_r == 32'h0));
      check({tag, ".status"}, 64'(status), 64'(exp_st));
   endtask

   localparam logic [6:0] R = 7'h33, I = 7'h13;

   initial begin
      logic [31:0] a, b, er;
      logic [6:0]  opc, f7;
      logic [2:0]  f3;
      logic        ill;
      logic [6:0]  opc_tab [10] = '{7'h33, 7'h33, 7'h13, 7'h13, 7'h03, 7'h63, 7'h37, 7'h17, 7'h67, 7'h00};
      logic [6:0]  f7_tab  [4]  = '{7'h00, 7'h20, 7'h01, 7'h00};
      logic [31:0] edge_tab[6]  = '{32'h0, 32'h1, 32'h7, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF};

      // Reset with nonzero ADD inputs present: reset must win.
      @(negedge clk);
      rst = 1'b1; op1 = 32'd5; op2 = 32'd3; opcode = R; funct3 = 3'd0; funct7 = 7'h00;
      @(posedge clk);
      #1;
      check("reset.result", 64'(result), 64'h0);
      check("reset.zero",   64'(zero),   64'h1);
      check("reset.status", 64'(status), 64'h0);
      @(negedge clk);
      rst = 1'b0;

      apply("add",    32'd5, 32'd3, R, 3'd0, 7'h00, 32'd8, 1'b0);
      apply("sub",    32'd5, 32'd3, R, 3'd0, 7'h20, 32'd2, 1'b0);
      apply("and",    32'h0000_1001, 32'hFFFF_FFFF, R, 3'd7, 7'h00, 32'h0000_1001, 1'b0);
      apply("or",     32'h1111_1111, 32'h2222_2222, R, 3'd6, 7'h00, 32'h3333_3333, 1'b0);
      apply("xor",    32'h1111_0000, 32'h1110_1000, R, 3'd4, 7'h00, 32'h0001_1000, 1'b0);
      apply("sll",    32'd1, 32'd2, R, 3'd1, 7'h00, 32'd4, 1'b0);
      apply("srl",    32'h1000, 32'd2, R, 3'd5, 7'h00, 32'h400, 1'b0);
      apply("sra_p",  32'h0F, 32'd3, R, 3'd5, 7'h20, 32'd1, 1'b0);
      apply("sra_n",  32'h8000_0000, 32'd4, R, 3'd5, 7'h20, 32'hF800_0000, 1'b0);
      apply("slt",    32'hFFFF_FFFC, 32'd3, R, 3'd2, 7'h00, 32'd1, 1'b0);
      apply("sltu",   32'hFFFF_FFFC, 32'd3, R, 3'd3, 7'h00, 32'd0, 1'b0);
      apply("sll_wr", 32'd1, 32'h21, R, 3'd1, 7'h00, 32'd2, 1'b0);
      apply("mul",    32'd8, 32'd2, R, 3'd0, 7'h01, 32'h10, 1'b0);
      apply("mulh",   32'hFFFF_FFFF, 32'hFFFF_FFFF, R, 3'd1, 7'h01, 32'h0, 1'b0);
      apply("mulhu",  32'hFFFF_FFFF, 32'hFFFF_FFFF, R, 3'd3, 7'h01, 32'hFFFF_FFFE, 1'b0);
      apply("branch", 32'd7, 32'd7, 7'h63, 3'd0, 7'h00, 32'h0, 1'b0);
      apply("bad_op", 32'd7, 32'd7, 7'h7F, 3'd0, 7'h00, 32'h0, 1'b1);
      apply("bad_f7", 32'd7, 32'd7, R, 3'd7, 7'h20, 32'h0, 1'b1);
      apply("lui",    32'd9, 32'hABCD_E000, 7'h37, 3'd0, 7'h00, 32'hABCD_E000, 1'b0);
      apply("i_add",  32'd9, 32'hFFFF_FFFF, I, 3'd0, 7'h55, 32'd8, 1'b0);
      apply("i_srai", 32'h8000_0000, 32'd1, I, 3'd5, 7'h20, 32'hC000_0000, 1'b0);
      apply("i_bad",  32'd1, 32'd1, I, 3'd1, 7'h20, 32'h0, 1'b1);
`ifdef ALU_DIV_EN
      apply("div0",   32'd7, 32'd0, R, 3'd4, 7'h01, 32'hFFFF_FFFF, 1'b0);
      apply("rem0",   32'd7, 32'd0, R, 3'd6, 7'h01, 32'd7, 1'b0);
      apply("divovf", 32'h8000_0000, 32'hFFFF_FFFF, R, 3'd4, 7'h01, 32'h8000_0000, 1'b0);
      apply("removf", 32'h8000_0000, 32'hFFFF_FFFF, R, 3'd6, 7'h01, 32'h0, 1'b0);
      apply("div",    32'hFFFF_FFF9, 32'd2, R, 3'd4, 7'h01, 32'hFFFF_FFFD, 1'b0);
`else
      apply("div_off", 32'd7, 32'd2, R, 3'd4, 7'h01, 32'h0, 1'b1);
`endif

      // Randomized ops, operands occasionally forced to edge values.
      for (int i = 0; i < 400; i++) begin
         a   = ($urandom_range(0, 3) == 0) ? edge_tab[$urandom_range(0, 5)] : $urandom;
         b   = ($urandom_range(0, 3) == 0) ? edge_tab[$urandom_range(0, 5)] : $urandom;
         opc = opc_tab[$urandom_range(0, 9)];
         if (opc == 7'h00) opc = 7'($urandom);
         f3  = 3'($urandom);
         f7  = f7_tab[$urandom_range(0, 3)];
         if ($urandom_range(0, 9) == 0) f7 = 7'($urandom);
         model(a, b, opc, f3, f7, er, ill);
         apply("rand", a, b, opc, f3, f7, er, ill);
      end

      // Reset mid-stream after a nonzero result.
      apply("pre_rst", 32'd1, 32'd1, R, 3'd0, 7'h00, 32'd2, 1'b0);
      @(negedge clk);
      rst = 1'b1; opcode = 7'h7F;
      @(posedge clk);
      #1;
      check("rst2.result", 64'(result), 64'h0);
      check("rst2.zero",   64'(zero),   64'h1);
      check("rst2.status", 64'(status), 64'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
